dual_input_debouncer: RTL and testbench

//   Conditions two raw, asynchronous, bouncy inputs (switches/buttons) into clean,

---
 rtl/dual_input_debouncer.sv | 162 ++++++++++++++++
 tb/tb_dual_input_debouncer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dual_input_debouncer.sv
// Two-channel raw input conditioner: per-channel synchroniser plus counter-based
// debounce FSM, with registered edge pulses and a shared saturating glitch counter.
module dual_input_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                raw_a,
  input  logic                raw_b,
  output logic                a,
  output logic                b,
  output logic                a_rise,
  output logic                a_fall,
  output logic                b_rise,
  output logic                b_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned NCH    = 2;
  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned GSUM_W = GLITCH_W + 1;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  logic [NCH-1:0]                  raw;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                          state_q [NCH];
  state_e                          state_d [NCH];
  logic [NCH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NCH-1:0]                  out_q, out_d;
  logic [NCH-1:0]                  rise_q, rise_d;
  logic [NCH-1:0]                  fall_q, fall_d;
  logic [GLITCH_W-1:0]             glitch_q, glitch_d;
  logic [1:0]                      glitch_inc;
  logic [GSUM_W-1:0]               glitch_sum;
  logic                            s;

  assign raw = {raw_b, raw_a};

  // Next-state logic for synchronisers, debounce FSMs, pulses and glitch count
  always_comb begin
    sync_d     = sync_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    rise_d     = '0;
    fall_d     = '0;
    glitch_inc = 2'd0;
    s          = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      sync_d[ch]  = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      s           = sync_q[ch][SYNC_STAGES-1];
      unique case (state_q[ch])
        STABLE_LO: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              out_d[ch]   = 1'b1;
              rise_d[ch]  = 1'b1;
              state_d[ch] = STABLE_HI;
            end else begin
              state_d[ch] = WAIT_HI;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d[ch] = STABLE_LO;
            cnt_d[ch]   = '0;
            glitch_inc  = glitch_inc + 2'd1;
          end else if (cnt_q[ch] == CNT_LAST) begin
            out_d[ch]   = 1'b1;
            rise_d[ch]  = 1'b1;
            state_d[ch] = STABLE_HI;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              out_d[ch]   = 1'b0;
              fall_d[ch]  = 1'b1;
              state_d[ch] = STABLE_LO;
            end else begin
              state_d[ch] = WAIT_LO;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d[ch] = STABLE_HI;
            cnt_d[ch]   = '0;
            glitch_inc  = glitch_inc + 2'd1;
          end else if (cnt_q[ch] == CNT_LAST) begin
            out_d[ch]   = 1'b0;
            fall_d[ch]  = 1'b1;
            state_d[ch] = STABLE_LO;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        default: begin
          state_d[ch] = STABLE_LO;
          cnt_d[ch]   = '0;
        end
      endcase
    end
    // Both channels may abort on one edge; clamp rather than wrap
    glitch_sum = GSUM_W'(glitch_q) + GSUM_W'(glitch_inc);
    if (glitch_sum > {1'b0, GLITCH_MAX}) begin
      glitch_d = GLITCH_MAX;
    end else begin
      glitch_d = glitch_sum[GLITCH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= STABLE_LO;
      end
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
      end
    end
  end

  assign a          = out_q[0];
  assign b          = out_q[1];
  assign a_rise     = rise_q[0];
  assign a_fall     = fall_q[0];
  assign b_rise     = rise_q[1];
  assign b_fall     = fall_q[1];
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Directed scoreboard bench for dual_input_debouncer: default instance plus a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance sharing clock and reset.
module tb_dual_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic       raw_a, raw_b, raw2_a, raw2_b;
  logic       a, b, a_rise, a_fall, b_rise, b_fall;
  logic [7:0] glitch_cnt;
  logic       a2, b2, a2_rise, a2_fall, b2_rise, b2_fall;
  logic [7:0] glitch2_cnt;

  int checks   = 0;
  int failures = 0;
  int g        = 0;

  typedef struct {
    string       tag;
    logic [13:0] exp;
    bit          d2;
  } sb_t;

  sb_t sb_q [$];

  dual_input_debouncer u_dut (
    .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .glitch_cnt(glitch_cnt)
  );

  dual_input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .GLITCH_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .raw_a(raw2_a), .raw_b(raw2_b),
    .a(a2), .b(b2), .a_rise(a2_rise), .a_fall(a2_fall),
    .b_rise(b2_rise), .b_fall(b2_fall), .glitch_cnt(glitch2_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] pk(input logic ea, input logic eb, input logic ear,
                                     input logic eaf, input logic ebr, input logic ebf,
                                     input logic [7:0] eg);
    return {ea, eb, ear, eaf, ebr, ebf, eg};
  endfunction

  task automatic push(input string tag, input logic [13:0] e, input bit d2);
    sb_t ent;
    ent.tag = tag;
    ent.exp = e;
    ent.d2  = d2;
    sb_q.push_back(ent);
  endtask

  task automatic sample();
    sb_t         ent;
    logic [13:0] obs;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      ent = sb_q.pop_front();
      obs = ent.d2 ? {a2, b2, a2_rise, a2_fall, b2_rise, b2_fall, glitch2_cnt}
                   : {a, b, a_rise, a_fall, b_rise, b_fall, glitch_cnt};
      assert (obs === ent.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h (a,b,ar,af,br,bf,glitch)", ent.tag, obs, ent.exp);
      end
    end
  endtask

  // Push the expected output for each upcoming edge, then compare just after it
  task automatic run(input string tag, input int n, input logic [13:0] e, input bit d2);
    for (int i = 0; i < n; i++) begin
      push(tag, e, d2);
      @(posedge clk);
      #1;
      sample();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_a  = 1'b0;
    raw_b  = 1'b0;
    raw2_a = 1'b0;
    raw2_b = 1'b0;
    #1;
    push("reset_async", 14'h0, 1'b0);
    sample();
    run("reset_hold", 3, 14'h0, 1'b0);
    rst_n = 1'b1;
    run("idle", 20, 14'h0, 1'b0);
    run("idle_d2", 3, 14'h0, 1'b1);

    // Clean A step: accepted on the sixth edge only
    raw_a = 1'b1;
    run("a_wait", 5, 14'h0, 1'b0);
    run("a_rise", 1, pk(1, 0, 1, 0, 0, 0, 8'd0), 1'b0);
    run("a_hold", 2, pk(1, 0, 0, 0, 0, 0, 8'd0), 1'b0);

    // Three-sample B glitches, repeated past saturation
    for (int it = 0; it < 300; it++) begin
      raw_b = 1'b1;
      run("b_glitch_hi", 3, pk(1, 0, 0, 0, 0, 0, 8'(g)), 1'b0);
      raw_b = 1'b0;
      run("b_glitch_lo", 2, pk(1, 0, 0, 0, 0, 0, 8'(g)), 1'b0);
      g = (g < 255) ? g + 1 : 255;
      run("b_glitch_cnt", 1, pk(1, 0, 0, 0, 0, 0, 8'(g)), 1'b0);
    end

    raw_b = 1'b1;
    run("b_wait", 5, pk(1, 0, 0, 0, 0, 0, 8'd255), 1'b0);
    run("b_rise", 1, pk(1, 1, 0, 0, 1, 0, 8'd255), 1'b0);
    run("both_hi", 2, pk(1, 1, 0, 0, 0, 0, 8'd255), 1'b0);

    // Simultaneous falls on both channels
    raw_a = 1'b0;
    raw_b = 1'b0;
    run("fall_wait", 5, pk(1, 1, 0, 0, 0, 0, 8'd255), 1'b0);
    run("fall_both", 1, pk(0, 0, 0, 1, 0, 1, 8'd255), 1'b0);
    run("fall_after", 2, pk(0, 0, 0, 0, 0, 0, 8'd255), 1'b0);

    // Reset while A is mid-wait
    raw_a = 1'b1;
    run("rst_pre", 3, pk(0, 0, 0, 0, 0, 0, 8'd255), 1'b0);
    rst_n = 1'b0;
    #1;
    push("rst_mid_async", 14'h0, 1'b0);
    sample();
    run("rst_mid_hold", 2, 14'h0, 1'b0);
    rst_n = 1'b1;
    run("rst_rel_wait", 5, 14'h0, 1'b0);
    run("rst_rel_rise", 1, pk(1, 0, 1, 0, 0, 0, 8'd0), 1'b0);
    run("rst_rel_hold", 1, pk(1, 0, 0, 0, 0, 0, 8'd0), 1'b0);

    // Fast instance: no debounce, deeper synchroniser
    raw2_a = 1'b1;
    run("d2_wait", 3, 14'h0, 1'b1);
    run("d2_rise", 1, pk(1, 0, 1, 0, 0, 0, 8'd0), 1'b1);
    run("d2_hold", 1, pk(1, 0, 0, 0, 0, 0, 8'd0), 1'b1);
    raw2_a = 1'b0;
    run("d2_fall_wait", 3, pk(1, 0, 0, 0, 0, 0, 8'd0), 1'b1);
    run("d2_fall", 1, pk(0, 0, 0, 1, 0, 0, 8'd0), 1'b1);
    run("d2_idle", 2, 14'h0, 1'b1);
    raw2_a = 1'b1;
    run("d2_pulse_in", 1, 14'h0, 1'b1);
    raw2_a = 1'b0;
    run("d2_pulse_wait", 2, 14'h0, 1'b1);
    run("d2_pulse_rise", 1, pk(1, 0, 1, 0, 0, 0, 8'd0), 1'b1);
    run("d2_pulse_fall", 1, pk(0, 0, 0, 1, 0, 0, 8'd0), 1'b1);
    run("d2_pulse_end", 1, 14'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
